// File: rtl/pipe_sequencer.sv
// pipe_sequencer: frame-synchronous controller for the capture pipeline.
// Sequences camera configuration with timeout and retry. Aligns pipe flushes and Gaussian LPF
// enable changes to start-of-frame. Counts frame-buffer writes per frame. Resynchronises to the
// next frame after an LPF error.
// Ports:
//   i_clk, i_rstn      clock, synchronous active-low reset
//   i_sof              start-of-frame pulse
//   i_cfg_done         camera config complete (level)
//   i_sw_gaussian      asynchronous board switch, synchronised here
//   i_lpf_error        LPF error (level or pulse)
//   i_wr               frame-buffer write strobe
//   o_cfg_start        one-cycle config start pulse
//   o_gaussian_enable  LPF enable, changes only at a flush start
//   o_pipe_flush       pipeline flush
//   o_frame_done/err   frame closed with exact / wrong write count
//   o_frame_count      good-frame counter (wraps)
//   o_fault            sticky config failure
//   o_state            IDLE=0 CFG=1 SYNC=2 FLUSH=3 RUN=4 FAULT=5
module pipe_sequencer #(
  parameter int unsigned FRAME_PIXELS = 230400,
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter int unsigned CFG_TIMEOUT  = 12500000,
  parameter int unsigned CFG_RETRIES  = 3
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_sof,
  input  logic        i_cfg_done,
  input  logic        i_sw_gaussian,
  input  logic        i_lpf_error,
  input  logic        i_wr,
  output logic        o_cfg_start,
  output logic        o_gaussian_enable,
  output logic        o_pipe_flush,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [15:0] o_frame_count,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCfg   = 3'd1,
    StSync  = 3'd2,
    StFlush = 3'd3,
    StRun   = 3'd4,
    StFault = 3'd5
  } state_e;

  localparam int unsigned TimerW = $clog2(CFG_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                started_q, started_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [7:0]          retry_q, retry_d;
  logic [7:0]          flush_cnt_q, flush_cnt_d;
  logic [17:0]         wr_cnt_q, wr_cnt_d;
  logic [17:0]         wr_total;
  logic                sw_meta_q, sw_sync_q;
  logic                cfg_start_q, cfg_start_d;
  logic                gauss_q, gauss_d;
  logic                flush_q, flush_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                fault_q, fault_d;
  logic                enter_cfg, enter_flush;

  // A write coincident with the closing sof belongs to the closing frame.
  assign wr_total = (wr_cnt_q == 18'h3ffff) ? wr_cnt_q : wr_cnt_q + {17'd0, i_wr};

  always_comb begin
    state_d       = state_q;
    started_d     = started_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    flush_cnt_d   = flush_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    cfg_start_d   = 1'b0;
    gauss_d       = gauss_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    frame_count_d = frame_count_q;
    enter_cfg     = 1'b0;
    enter_flush   = 1'b0;

    unique case (state_q)
      // started_q gives IDLE one visible cycle after reset release.
      StIdle: begin
        if (started_q) enter_cfg = 1'b1;
        else           started_d = 1'b1;
      end
      StCfg: begin
        if (i_cfg_done) begin
          state_d = StSync;
        end else if (timer_q == TimerW'(CFG_TIMEOUT)) begin
          if (retry_q < 8'(CFG_RETRIES)) enter_cfg = 1'b1;
          else                           state_d   = StFault;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSync: begin
        if (i_sof) enter_flush = 1'b1;
      end
      StFlush: begin
        if (flush_cnt_q == 8'(FLUSH_CYCLES - 1)) begin
          state_d  = StRun;
          wr_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (i_lpf_error) begin
          // Error wins over a coincident sof; the partial frame is dropped silently.
          state_d = StSync;
        end else if (i_sof) begin
          if (wr_total == 18'(FRAME_PIXELS)) begin
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
          wr_cnt_d = '0;
          if (sw_sync_q != gauss_q) enter_flush = 1'b1;
        end else begin
          wr_cnt_d = wr_total;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    if (enter_cfg) begin
      state_d     = StCfg;
      cfg_start_d = 1'b1;
      timer_d     = '0;
      retry_d     = retry_q + 8'd1;
    end
    if (enter_flush) begin
      state_d     = StFlush;
      flush_cnt_d = '0;
      gauss_d     = sw_sync_q;
    end
  end

  assign flush_d = (state_d == StFlush);
  assign fault_d = (state_d == StFault);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q       <= StIdle;
      started_q     <= 1'b0;
      timer_q       <= '0;
      retry_q       <= '0;
      flush_cnt_q   <= '0;
      wr_cnt_q      <= '0;
      sw_meta_q     <= 1'b0;
      sw_sync_q     <= 1'b0;
      cfg_start_q   <= 1'b0;
      gauss_q       <= 1'b0;
      flush_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= started_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      flush_cnt_q   <= flush_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      sw_meta_q     <= i_sw_gaussian;
      sw_sync_q     <= sw_meta_q;
      cfg_start_q   <= cfg_start_d;
      gauss_q       <= gauss_d;
      flush_q       <= flush_d;
      done_q        <= done_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
      fault_q       <= fault_d;
    end
  end

  assign o_cfg_start       = cfg_start_q;
  assign o_gaussian_enable = gauss_q;
  assign o_pipe_flush      = flush_q;
  assign o_frame_done      = done_q;
  assign o_frame_err       = err_q;
  assign o_frame_count     = frame_count_q;
  assign o_fault           = fault_q;
  assign o_state           = state_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer with a frame-result scoreboard.
module tb_pipe_sequencer;

  localparam int unsigned Fp    = 40;
  localparam int unsigned Flush = 16;
  localparam int unsigned Tmo   = 100;
  localparam int unsigned Retry = 3;

  logic        clk = 1'b0;
  logic        rstn, sof, cfg_done, sw, lpf_err, wr;
  logic        cfg_start, gauss, flush, frame_done, frame_err, fault;
  logic [15:0] frame_count;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_count = 0;

  typedef struct {
    bit          done;
    int unsigned count;
  } frame_exp_t;
  frame_exp_t exp_q[$];

  pipe_sequencer #(
    .FRAME_PIXELS(Fp),
    .FLUSH_CYCLES(Flush),
    .CFG_TIMEOUT (Tmo),
    .CFG_RETRIES (Retry)
  ) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_sof            (sof),
    .i_cfg_done       (cfg_done),
    .i_sw_gaussian    (sw),
    .i_lpf_error      (lpf_err),
    .i_wr             (wr),
    .o_cfg_start      (cfg_start),
    .o_gaussian_enable(gauss),
    .o_pipe_flush     (flush),
    .o_frame_done     (frame_done),
    .o_frame_err      (frame_err),
    .o_frame_count    (frame_count),
    .o_fault          (fault),
    .o_state          (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard consumer and enable-change monitor.
  logic prev_gauss = 1'b0;
  logic prev_flush = 1'b0;
  always @(posedge clk) begin
    #2;
    if (frame_done || frame_err) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_frame_pulse", 32'(frame_done) + 32'(frame_err), 0);
      end else begin
        frame_exp_t e;
        e = exp_q.pop_front();
        check_eq("frame_done", 32'(frame_done), 32'(e.done));
        check_eq("frame_err", 32'(frame_err), 32'(!e.done));
        check_eq("frame_count", 32'(frame_count), e.count);
      end
    end
    if (gauss !== prev_gauss && state != 3'd0)
      check_eq("gauss_change_at_flush_start", 32'(flush && !prev_flush), 1);
    prev_gauss = gauss;
    prev_flush = flush;
  end

  // Counts the flush pulse that is already high and checks the RUN hand-off.
  task automatic flush_count(input bit noisy);
    int n = 0;
    check_eq("flush_high_at_entry", 32'(flush), 1);
    if (noisy) begin
      wr = 1'b1;
      lpf_err = 1'b1;
    end
    while (flush && n < 300) begin
      n++;
      step(1);
    end
    wr = 1'b0;
    lpf_err = 1'b0;
    check_eq("flush_len", n, Flush);
    check_eq("run_after_flush", 32'(state), 4);
  endtask

  task automatic sof_to_run(input bit noisy);
    sof = 1'b1;
    step(1);
    sof = 1'b0;
    check_eq("flush_state", 32'(state), 3);
    flush_count(noisy);
  endtask

  task automatic run_frame(input int nwr, input bit wr_on_sof, input bit gap);
    int total = nwr + int'(wr_on_sof);
    frame_exp_t e;
    for (int i = 0; i < nwr; i++) begin
      wr = 1'b1;
      step(1);
      if (gap) begin
        wr = 1'b0;
        step(1);
      end
    end
    wr = 1'b0;
    e.done = (total == int'(Fp));
    if (e.done) exp_count++;
    e.count = 32'(exp_count) & 32'hffff;
    exp_q.push_back(e);
    sof = 1'b1;
    wr  = wr_on_sof;
    step(1);
    sof = 1'b0;
    wr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_prev;
    int pulses;
    int t_fault;
    rstn = 1'b0; sof = 1'b0; cfg_done = 1'b0; sw = 1'b0; lpf_err = 1'b0; wr = 1'b0;
    step(3);
    check_eq("reset_outputs",
             {cfg_start, gauss, flush, frame_done, frame_err, fault, frame_count, state}, 0);

    // Bring-up
    rstn = 1'b1;
    step(1);
    check_eq("idle_cycle_state", 32'(state), 0);
    check_eq("idle_cycle_no_start", 32'(cfg_start), 0);
    step(1);
    check_eq("cfg_start_at_2", 32'(cfg_start), 1);
    check_eq("cfg_state", 32'(state), 1);
    step(1);
    check_eq("cfg_start_one_cycle", 32'(cfg_start), 0);
    step(40);
    cfg_done = 1'b1;
    step(1);
    check_eq("sync_after_done", 32'(state), 2);
    wr = 1'b1;
    step(3);
    wr = 1'b0;
    sof_to_run(1'b0);
    run_frame(Fp, 1'b0, 1'b0);
    check_eq("stay_run", 32'(state), 4);

    // Write-count boundaries
    run_frame(Fp - 1, 1'b0, 1'b1);
    run_frame(Fp - 1, 1'b1, 1'b0);
    run_frame(Fp + 1, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    check_eq("frame_count_total", 32'(frame_count), exp_count);

    // Gaussian switch: several toggles, only the final value counts at the next sof
    sw = 1'b1; step(2); sw = 1'b0; step(2); sw = 1'b1;
    step(5);
    check_eq("gauss_hold_midframe", 32'(gauss), 0);
    run_frame(Fp, 1'b0, 1'b0);
    check_eq("gauss_new_value", 32'(gauss), 1);
    flush_count(1'b0);
    sw = 1'b0; step(3); sw = 1'b1; step(3);
    run_frame(Fp, 1'b0, 1'b0);
    check_eq("no_flush_same_value", 32'(state), 4);
    check_eq("gauss_unchanged", 32'(gauss), 1);

    // LPF error coincident with sof
    wr = 1'b1; step(10); wr = 1'b0;
    sof = 1'b1; lpf_err = 1'b1;
    step(1);
    sof = 1'b0; lpf_err = 1'b0;
    check_eq("lpf_to_sync", 32'(state), 2);
    check_eq("lpf_count_kept", 32'(frame_count), exp_count);
    wr = 1'b1; step(5); wr = 1'b0;
    sof_to_run(1'b1);  // writes and errors during flush are ignored
    run_frame(Fp, 1'b0, 1'b0);
    wr = 1'b1; step(3); wr = 1'b0;
    lpf_err = 1'b1; step(1); lpf_err = 1'b0;
    check_eq("lpf_midframe_sync", 32'(state), 2);
    sof_to_run(1'b0);
    run_frame(Fp - 1, 1'b0, 1'b0);

    // Reset 5 cycles into a flush
    lpf_err = 1'b1; step(1); lpf_err = 1'b0;
    sof = 1'b1; step(1); sof = 1'b0;
    step(4);
    check_eq("flush_before_reset", 32'(flush), 1);
    cfg_done = 1'b0;
    rstn = 1'b0;
    step(1);
    check_eq("reset_mid_flush",
             {cfg_start, gauss, flush, frame_done, frame_err, fault, frame_count, state}, 0);
    exp_count = 0;
    rstn = 1'b1;
    step(1);
    check_eq("rst2_idle_no_start", 32'(cfg_start), 0);
    step(1);
    check_eq("rst2_cfg_start", 32'(cfg_start), 1);

    // Config timeout and retry to fault
    t_prev = cyc;
    pulses = 1;
    t_fault = -1;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (cfg_start) begin
        check_eq("retry_gap", cyc - t_prev, Tmo + 1);
        t_prev = cyc;
        pulses++;
      end
      if (fault && t_fault < 0) t_fault = cyc;
    end
    check_eq("cfg_pulses", pulses, Retry);
    check_eq("fault_delay", t_fault - t_prev, Tmo + 1);
    check_eq("fault_flag", 32'(fault), 1);
    check_eq("fault_state", 32'(state), 5);
    cfg_done = 1'b1; sof = 1'b1;
    step(3);
    sof = 1'b0;
    check_eq("fault_sticky", 32'(state), 5);
    check_eq("fault_quiet", {cfg_start, flush, frame_done, frame_err}, 0);

    step(2);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Frame-synchronous controller for the 125 MHz capture pipeline: camera config, Gaussian LPF, color detection and frame-buffer writer. It sequences camera configuration with timeout and retry, aligns pipeline flushes and Gaussian enable changes to start-of-frame, counts frame-buffer writes per frame, and recovers from LPF errors by resynchronising to the next frame. It sits beside the camera block and drives its config start, the LPF enable/flush inputs and the memory-interface flush.

## Interface
- FRAME_PIXELS, 230400: expected frame-buffer writes per frame.
- FLUSH_CYCLES, 16: length of each pipe flush pulse, in cycles; legal range 1..255.
- CFG_TIMEOUT, 12500000: cycles to wait for cfg done (100 ms at 125 MHz).
- CFG_RETRIES, 3: config attempts before fault.
- i_clk  in  1  125 MHz system clock; sole clock.
- i_rstn  in  1  synchronous, active-low reset.
- i_sof  in  1  start-of-frame pulse, one cycle, i_clk domain.
- i_cfg_done  in  1  camera config complete, level.
- i_sw_gaussian  in  1  asynchronous board switch; double-flop synchronised internally.
- i_lpf_error  in  1  LPF error, level or pulse.
- i_wr  in  1  frame-buffer write strobe.
- o_cfg_start  out  1  one-cycle config start pulse.
- o_gaussian_enable  out  1  LPF enable; changes only at a flush start.
- o_pipe_flush  out  1  pipeline flush.
- o_frame_done  out  1  one-cycle pulse when a frame closes with exactly FRAME_PIXELS writes.
- o_frame_err  out  1  one-cycle pulse when a frame closes with any other write count.
- o_frame_count  out  16  good-frame counter; wraps.
- o_fault  out  1  config failed after all retries; sticky.
- o_state  out  3  encoding: IDLE=0, CFG=1, SYNC=2, FLUSH=3, RUN=4, FAULT=5.

## Operation
- All outputs registered. Reset values are 0 for every output; o_state=IDLE.
- IDLE: one cycle, then CFG.
- CFG entry:
  - o_cfg_start pulses for 1 cycle.
  - Timeout counter cleared.
  - Retry counter incremented.
- CFG exit:
  - i_cfg_done=1 -> SYNC.
  - Counter reaches CFG_TIMEOUT with retries < CFG_RETRIES -> re-enter CFG, which pulses o_cfg_start again.
  - Otherwise -> FAULT.
- SYNC: waits for i_sof, then -> FLUSH. i_wr is ignored.
- FLUSH entry:
  - o_gaussian_enable loads the synchronised switch value.
  - o_pipe_flush=1 for exactly FLUSH_CYCLES cycles, then -> RUN.
  - i_wr, i_sof and i_lpf_error are ignored.
- RUN entry: the write counter (18-bit, saturating at 2^18-1) is cleared. Each i_wr increments it.
- RUN on i_sof (frame close):
  - Count == FRAME_PIXELS: o_frame_done pulses and o_frame_count increments.
  - Any other count: o_frame_err pulses.
  - Write counter cleared.
  - If the synchronised switch differs from o_gaussian_enable -> FLUSH. Otherwise stay in RUN.
- RUN on i_lpf_error=1 -> SYNC. The partial frame is discarded without a done or err pulse.
- Simultaneous i_sof and i_lpf_error in RUN: the error wins. No frame pulse; -> SYNC.
- i_wr and i_sof in the same RUN cycle: the write belongs to the closing frame and is counted before the compare. The new frame starts at 0.
- Switch toggles mid-frame: no effect until the next sof. Several toggles within one frame act on the final value only.
- FAULT: o_fault=1. All other outputs hold 0, except o_gaussian_enable, which holds its last value. Left only by reset.
- Reset mid-operation (any state): next cycle all outputs are at reset values and the sequence restarts from IDLE, including a fresh cfg start. Retry counter cleared.

## Timing
- o_cfg_start rises 2 cycles after i_rstn deasserts (IDLE, then CFG entry).
- i_cfg_done sampled high in cycle N: o_state=SYNC at N+1.
- i_sof in SYNC at cycle N: o_pipe_flush=1 over cycles N+1 .. N+FLUSH_CYCLES. o_state=RUN at N+FLUSH_CYCLES+1.
- o_frame_done / o_frame_err assert the cycle after the closing i_sof. o_frame_count updates in the same cycle.
- Switch path latency to a decision: 2 cycles of synchroniser.
- Timeout: with i_cfg_done low, a retry pulse occurs CFG_TIMEOUT+1 cycles after the previous pulse.

## Test plan
- Bring-up: reset release, i_cfg_done after 100 cycles, sof, then 230400 i_wr, then sof -> o_cfg_start pulse at cycle 2, flush high 16 cycles, o_frame_done pulse, o_frame_count=1.
- Short frame: only 230399 writes between sofs -> o_frame_err pulse, no o_frame_done, o_frame_count unchanged. The next full frame yields done with count=1.
- Config timeout: CFG_TIMEOUT=100, i_cfg_done held 0 -> exactly 3 o_cfg_start pulses 101 cycles apart, then o_fault=1 and o_state=5 until reset.
- Gaussian switch: toggle i_sw_gaussian mid-frame -> o_gaussian_enable changes only on the cycle after the next sof, together with a 16-cycle flush. No change before that sof.
- LPF error: i_lpf_error coincident with sof in RUN -> no done/err pulse, o_state=SYNC. The next sof produces a flush, then RUN.
- Reset during FLUSH, 5 cycles in -> all outputs 0 next cycle, o_state=IDLE, fresh o_cfg_start 2 cycles after release.
